bram_stream_reader: RTL and testbench

Sequential read engine that drives one port of a synchronous-read BRAM block and presents the contents as a valid/ready stream. A command (start address, length) is accepted over a handshake. The block then issues one address per cycle, absorbs the one-cycle BRAM read latency, and emits each word with a last flag. A 3-entry output buffer lets it sustain one word per cycle under backpressure with no combinational path from out_ready to mem_addr. It is used to drain tables and buffers held in bram_block instances, for example for trace dump or DMA-style copy.

---
 rtl/bram_stream_reader.sv | 105 ++++++++++
 tb/tb_bram_stream_reader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: streams start_len words out of a synchronous-read BRAM as valid/ready beats with a last flag
module bram_stream_reader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [AW-1:0]    start_addr,
  input  logic [AW:0]      start_len,
  input  logic             abort,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_din,
  input  logic [WIDTH-1:0] mem_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t           state_q, state_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      rem_q, rem_d;
  logic             infl_q, infl_d, infl_last_q, infl_last_d;
  logic [WIDTH-1:0] data_q [3];
  logic [WIDTH-1:0] data_d [3];
  logic [2:0]       last_q, last_d;
  logic [1:0]       cnt_q, cnt_d, wr_idx;
  logic             accept, issue, push, pop;
  assign start_ready = state_q == IDLE;
  assign busy        = !start_ready;
  assign mem_addr    = rd_ptr_q;
  assign mem_we      = 1'b0;
  assign mem_din     = '0;
  assign out_valid   = cnt_q != 2'd0;
  assign out_data    = data_q[0];
  assign out_last    = last_q[0];
  assign accept      = start_valid && start_ready && !abort;
  // Only registered occupancy gates issue, so out_ready never reaches mem_addr combinationally.
  assign issue       = state_q == RUN && rem_q != '0 && ({1'b0, cnt_q} + {2'b0, infl_q}) < 3'd3 && !abort;
  assign push        = infl_q;
  assign pop         = out_valid && out_ready;
  assign wr_idx      = cnt_q - {1'b0, pop};
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    rem_d       = rem_q;
    infl_d      = issue;
    infl_last_d = issue && rem_q == (AW+1)'(1);
    cnt_d       = cnt_q + {1'b0, push} - {1'b0, pop};
    data_d      = data_q;
    last_d      = last_q;
    if (pop) begin
      data_d[0] = data_q[1];
      data_d[1] = data_q[2];
      last_d    = {last_q[2], last_q[2], last_q[1]};
    end
    if (push) begin
      data_d[wr_idx] = mem_dout;
      last_d[wr_idx] = infl_last_q;
    end
    if (accept) begin
      rd_ptr_d = start_addr;
      rem_d    = start_len;
      state_d  = start_len == '0 ? DRAIN : RUN;
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q == AW'(DEPTH-1) ? '0 : rd_ptr_q + 1'b1;
      rem_d    = rem_q - 1'b1;
      state_d  = rem_q == (AW+1)'(1) ? DRAIN : RUN;
    end
    if (state_q == DRAIN && !infl_q && cnt_d == 2'd0) state_d = IDLE;
    if (abort) begin
      state_d     = IDLE;
      cnt_d       = 2'd0;
      infl_d      = 1'b0;
      infl_last_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      rem_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      cnt_q       <= 2'd0;
      last_q      <= 3'd0;
      for (int i = 0; i < 3; i++) data_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      rem_q       <= rem_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      for (int i = 0; i < 3; i++) data_q[i] <= data_d[i];
    end
  end
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: scoreboard bench driving bram_stream_reader against a behavioural BRAM and stream model
module tb_bram_stream_reader;
  localparam int W = 32;
  localparam int D = 32;
  localparam int AW = 5;
  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } exp_t;
  logic clk = 1'b0;
  logic reset, start_valid, start_ready, abort, mem_we, out_valid, out_ready, out_last, busy;
  logic [AW-1:0] start_addr, mem_addr;
  logic [AW:0] start_len;
  logic [W-1:0] mem_din, mem_dout, out_data;
  logic [W-1:0] mem [D];
  exp_t sb [$];
  int n_cmp = 0;
  int n_err = 0;
  int n_last = 0;

  always #5 clk = ~clk;
  always @(posedge clk) mem_dout <= mem[mem_addr];

  bram_stream_reader #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .start_addr(start_addr), .start_len(start_len), .abort(abort), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", out_data, $time);
        end else begin
          e = sb.pop_front();
          chk("word_data", out_data, e.d);
          chk("word_last", out_last, e.l);
          n_last += out_last;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input int a, input int n);
    exp_t e;
    start_valid = 1'b1;
    start_addr  = AW'(a);
    start_len   = (AW+1)'(n);
    for (int i = 0; i < n; i++) begin
      e.d = mem[(a + i) % D];
      e.l = (i == n - 1);
      sb.push_back(e);
    end
    @(negedge clk);
    chk("start_ready_at_accept", start_ready, 1);
    tick();
    start_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int k;
    for (k = 0; k < max; k++) begin
      @(negedge clk);
      if (start_ready) break;
      tick();
    end
    tick();
    chk("idle_timeout", k < max, 1);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    fork monitor(); join_none
    for (int i = 0; i < D; i++) mem[i] = 32'h1000 + i;
    reset = 1'b1; start_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
    start_addr = '0; start_len = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_start_ready", start_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    tick();
    // Basic run: words in cycles 3..7, idle in cycle 8
    issue_cmd(4, 5);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("t1_valid", out_valid, c >= 3 && c <= 7);
      chk("t1_start_ready", start_ready, c == 8);
      if (c == 1) chk("t1_first_addr", mem_addr, 4);
      tick();
    end
    chk("t1_drained", sb.size(), 0);
    // Address wrap
    issue_cmd(30, 4);
    wait_idle(20);
    // Backpressure: stall after three outstanding, release in cycle 10
    out_ready = 1'b0;
    issue_cmd(10, 8);
    for (int c = 1; c <= 18; c++) begin
      if (c == 10) out_ready = 1'b1;
      @(negedge clk);
      if (c < 10) chk("bp_addr", mem_addr, 10 + ((c - 1) < 3 ? c - 1 : 3));
      chk("bp_valid", out_valid, c >= 3 && c <= 17);
      chk("bp_start_ready", start_ready, c == 18);
      tick();
    end
    chk("bp_drained", sb.size(), 0);
    // Zero length
    issue_cmd(7, 0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("z_valid", out_valid, 0);
      chk("z_start_ready", start_ready, c >= 2);
      tick();
    end
    // Random contents, lengths and consumer stalls
    for (int i = 0; i < D; i++) mem[i] = $urandom;
    for (int t = 0; t < 6; t++) begin
      int a, n, k;
      a = $urandom_range(0, D - 1);
      n = (t == 0) ? D : $urandom_range(0, D);
      n_last = 0;
      out_ready = 1'($urandom_range(0, 1));
      issue_cmd(a, n);
      for (k = 0; k < 400; k++) begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (start_ready) break;
        tick();
      end
      tick();
      chk("rnd_timeout", k < 400, 1);
      chk("rnd_drained", sb.size(), 0);
      chk("rnd_last_count", n_last, n != 0);
    end
    // Abort in cycle 4, then a fresh command
    for (int i = 0; i < D; i++) mem[i] = 32'h1000 + i;
    out_ready = 1'b1;
    issue_cmd(2, 10);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sb.delete();
    for (int c = 5; c <= 8; c++) begin
      @(negedge clk);
      chk("ab_valid", out_valid, 0);
      chk("ab_start_ready", start_ready, 1);
      chk("ab_busy", busy, 0);
      tick();
    end
    issue_cmd(0, 2);
    wait_idle(20);
    // Reset mid-stream
    issue_cmd(5, 20);
    repeat (4) tick();
    reset = 1'b1;
    #1;
    chk("mr_valid", out_valid, 0);
    chk("mr_data", out_data, 0);
    chk("mr_last", out_last, 0);
    chk("mr_mem_addr", mem_addr, 0);
    chk("mr_busy", busy, 0);
    sb.delete();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mr_start_ready", start_ready, 1);
    tick();
    issue_cmd(9, 3);
    wait_idle(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
